// File: rtl/nios_i2c_acc_led_pwm_pio_if.sv
// Avalon-MM slave bus bundle for the LED PWM PIO.
//   address    : word address (3 bits)
//   chipselect : slave select
//   write_n    : active-low write strobe
//   writedata  : write data (32 bits)
//   readdata   : combinational read data (32 bits)
interface nios_i2c_acc_led_pwm_pio_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/nios_i2c_acc_led_pwm_pio.sv
// LED bank output PIO with atomic set/clear and per-channel PWM dimming.
// A shared prescaler produces a tick; a DUTY_W-bit PWM counter advances on
// each tick and channels with their MODE bit set are gated by pwm_on.
//   clk      : system clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : Avalon-MM slave (zero wait state, read latency 0)
//   out_port : registered LED drive, WIDTH bits
module nios_i2c_acc_led_pwm_pio #(
    parameter int WIDTH      = 10,
    parameter int DUTY_W     = 8,
    parameter int PRESCALE_W = 16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    nios_i2c_acc_led_pwm_pio_if.slave    bus,
    output logic [WIDTH-1:0]             out_port
);

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_MODE     = 3'd1;
    localparam logic [2:0] ADDR_DUTY     = 3'd2;
    localparam logic [2:0] ADDR_PRESCALE = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

    logic [WIDTH-1:0]      data_q;
    logic [WIDTH-1:0]      mode_q;
    logic [DUTY_W:0]       duty_q;
    logic [PRESCALE_W-1:0] prescale_q;
    logic [PRESCALE_W-1:0] pre_cnt;
    logic [DUTY_W-1:0]     pwm_cnt;

    logic wr_en;
    logic prescale_wr;
    logic tick;
    logic pwm_on;

    // Upper writedata bits beyond each register width are deliberately dropped.
    logic unused_wdata;
    assign unused_wdata = ^bus.writedata;

    assign wr_en       = bus.chipselect && !bus.write_n;
    assign prescale_wr = wr_en && (bus.address == ADDR_PRESCALE);
    assign tick        = (pre_cnt == prescale_q);
    // DUTY has one extra bit so values >= 2^DUTY_W saturate to always-on.
    assign pwm_on      = ({1'b0, pwm_cnt} < duty_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q     <= '0;
            mode_q     <= '0;
            duty_q     <= '0;
            prescale_q <= '0;
        end else if (wr_en) begin
            case (bus.address)
                ADDR_DATA:     data_q     <= bus.writedata[WIDTH-1:0];
                ADDR_MODE:     mode_q     <= bus.writedata[WIDTH-1:0];
                ADDR_DUTY:     duty_q     <= bus.writedata[DUTY_W:0];
                ADDR_PRESCALE: prescale_q <= bus.writedata[PRESCALE_W-1:0];
                ADDR_OUTSET:   data_q     <= data_q | bus.writedata[WIDTH-1:0];
                ADDR_OUTCLEAR: data_q     <= data_q & ~bus.writedata[WIDTH-1:0];
                default: ;
            endcase
        end
    end

    // A PRESCALE write restarts the period phase so software sees a
    // deterministic on-window right after reprogramming.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt <= '0;
            pwm_cnt <= '0;
        end else if (prescale_wr) begin
            pre_cnt <= '0;
            pwm_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
            pwm_cnt <= pwm_cnt + 1'b1;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_port <= '0;
        end else begin
            out_port <= data_q & (~mode_q | {WIDTH{pwm_on}});
        end
    end

    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            ADDR_DATA:     bus.readdata = 32'(data_q);
            ADDR_MODE:     bus.readdata = 32'(mode_q);
            ADDR_DUTY:     bus.readdata = 32'(duty_q);
            ADDR_PRESCALE: bus.readdata = 32'(prescale_q);
            default:       bus.readdata = '0;
        endcase
    end

endmodule

// File: doc/nios_i2c_acc_led_pwm_pio.md
# nios_i2c_acc_led_pwm_pio

Parametrised Avalon-MM output PIO for the board LED bank, the successor to the plain 10-bit LED PIO in the Nios II accelerometer system. It adds atomic bit set/clear registers and a per-channel PWM dimming mode. A shared prescaler and PWM counter generate the dimming. The Nios II drives it through the same zero-wait-state, read-latency-0 slave protocol. `out_port` connects directly to the LED pins.

## Interface
- `WIDTH`, 10, number of output channels (1..32).
- `DUTY_W`, 8, PWM counter width; one PWM period is 2^DUTY_W ticks.
- `PRESCALE_W`, 16, prescaler register and counter width (1..32).
- `clk` in 1: system clock; all logic on its rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `address` in 3: word address.
- `chipselect` in 1: slave select.
- `write_n` in 1: active-low write strobe.
- `writedata` in 32: write data.
- `readdata` out 32: combinational read data; unused upper bits are 0.
- `out_port` out WIDTH: registered LED drive.

## Operation
- Register map. A write occurs when `chipselect && !write_n`. Reads are combinational, valid in the same cycle as `address`.
  - 0 DATA: rw, WIDTH bits, static channel value.
  - 1 MODE: rw, WIDTH bits. Bit = 1 means the channel is PWM-gated.
  - 2 DUTY: rw, DUTY_W+1 bits, on-time in ticks.
  - 3 PRESCALE: rw, PRESCALE_W bits.
  - 4 OUTSET: write-only. DATA <= DATA | writedata[WIDTH-1:0]. Reads 0.
  - 5 OUTCLEAR: write-only. DATA <= DATA & ~writedata[WIDTH-1:0]. Reads 0.
  - 6, 7: reserved. Writes are ignored; reads return 0.
- Only one bus write is possible per cycle, so there is no set/clear/DATA conflict.
- Prescaler `pre_cnt`:
  - If `pre_cnt == PRESCALE`, then `pre_cnt <= 0` and `tick = 1` for that cycle.
  - Otherwise `pre_cnt` increments.
  - PRESCALE = 0 gives a tick every cycle.
- PWM counter `pwm_cnt` (DUTY_W bits) increments on `tick` and wraps from 2^DUTY_W−1 to 0.
- `pwm_on = ({1'b0, pwm_cnt} < DUTY)`. Consequences:
  - DUTY = 0: never on.
  - DUTY >= 2^DUTY_W: always on (saturates).
- A write to PRESCALE clears `pre_cnt` and `pwm_cnt` in the same edge. This restarts the period phase.
- A write to DUTY does not reset the counters. The new duty applies from the next comparison.
- `out_port <= DATA & (~MODE | {WIDTH{pwm_on}})`, evaluated on register values before the edge.
- Bits of `writedata` above each register's width are ignored.

## Timing
- Reset: DATA, MODE, DUTY, PRESCALE, `pre_cnt`, `pwm_cnt` and `out_port` are all 0. `readdata` reflects these zero values.
- Register write: the register updates at edge N.
  - `readdata` shows the new value from cycle N+1.
  - `out_port` reflects it at edge N+1 (one-cycle output latency).
- PWM period = (PRESCALE+1) × 2^DUTY_W clk cycles.
- On-time per period = min(DUTY, 2^DUTY_W) × (PRESCALE+1) cycles.
- After a PRESCALE write at edge N:
  - The first `tick` occurs at edge N+PRESCALE+1 (`pre_cnt` counts 0..PRESCALE).
  - PWM-gated outputs are high from edge N+1 if DUTY > 0.
- Reset assertion mid-period immediately clears all state, including `out_port`. There is no glitch-protection requirement.
- Static channels (MODE bit = 0) are unaffected by prescaler/PWM activity and by PRESCALE/DUTY writes.

## Test plan
- Reset: assert `reset_n`=0 with all registers loaded → `out_port`=0; reads of addresses 0–7 return 0 after release.
- Static path, WIDTH=10: write DATA=0x3FF, then OUTCLEAR=0x00F, then OUTSET=0x001 → DATA reads 0x3F0 then 0x3F1; `out_port` follows one cycle after each write; reads of addresses 4 and 5 return 0.
- PWM, DUTY_W=8, PRESCALE=0, DUTY=64, MODE=0x001, DATA=0x001 → `out_port[0]` high for exactly 64 of every 256 cycles, measured over 4 periods; all other bits stay 0.
- Saturation and edge cases, PRESCALE=3:
  - DUTY=0 → bit constantly 0.
  - DUTY=256 → bit constantly 1.
  - DUTY=300 → bit constantly 1.
  - Period check at DUTY=128 → 512 high / 512 low cycles.
- Phase restart: mid-period write PRESCALE=1 with DUTY=2 → output high for cycles N+1..N+4, low until N+512, and the pattern repeats.
- Mixed modes: MODE=0x2AA, DATA=0x3FF, DUTY=1, PRESCALE=0 → even bits constantly 1; odd bits high 1 cycle per 256. Reset asserted mid-high-pulse → all bits 0 asynchronously.
